trap_peak_detector: RTL and testbench
=====================================

# trap_peak_detector

Downstream stage of the trapezoidal shaping filter. Consumes the filter's signed output stream one sample per clock, detects pulses crossing a threshold, and reports each pulse's maximum amplitude with the timestamp of that maximum and a pile-up flag. Its output feeds the event/readout logic as a one-cycle-valid record per pulse.

## Interface

- FILTER_W, 22: width of filter sample and reported amplitude, signed two's complement
- TS_W, 32: timestamp counter width
- THRESHOLD, 100: signed trigger level; a sample is "above" when strictly greater
- HOLDOFF, 4: accepted samples ignored after each emitted peak
- MAX_WIDTH, 16: maximum accepted samples in a pulse before it is declared pile-up


- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- in_data  in  FILTER_W  signed filter output sample
- in_valid  in  1  in_data is valid this cycle
- peak_amplitude  out  FILTER_W  signed maximum of the pulse, held until next peak_valid
- peak_time  out  TS_W  timestamp of the cycle in which the maximum sample was presented, held
- peak_pileup  out  1  pulse exceeded MAX_WIDTH, held
- peak_valid  out  1  one-cycle strobe, new record on the three outputs above
- busy  out  1  state is not IDLE

## Operation

- Free-running timestamp counter ts: increments every clock regardless of in_valid; wraps modulo 2^TS_W with no flag.
- All comparisons signed. Only cycles with in_valid=1 are "accepted samples"; with in_valid=0 state, max, width and holdoff counters are frozen.
- prev_above register: whether the last accepted sample was above THRESHOLD; reset 0.
- FSM:
  - IDLE: accepted sample above and prev_above=0 (rising crossing) -> RISE; max<=sample, max_ts<=ts, width<=1. Sample above with prev_above=1 does not trigger (no retrigger on a stuck-high input).
  - RISE: accepted sample above: if sample > max (strict; first occurrence wins ties) update max, max_ts; width<=width+1. If width+1 reaches MAX_WIDTH: emit with pileup=1, -> HOLDOFF. Accepted sample not above: emit with pileup=0, -> HOLDOFF. Falling crossing on the sample that would hit MAX_WIDTH counts as normal end (pileup=0).
  - HOLDOFF: counts HOLDOFF accepted samples, then -> IDLE. Crossings during holdoff ignored; prev_above still tracks every accepted sample, so a pulse still high at holdoff end does not trigger.
  - HOLDOFF=0: RISE goes directly to IDLE.
- Emit: peak_amplitude<=max (including the current sample if it updated max in the same cycle), peak_time<=max_ts, peak_pileup set, peak_valid<=1 for exactly one cycle.
- Reset mid-pulse: pulse discarded, no peak_valid, FSM to IDLE.

## Timing

- Reset values: peak_amplitude=0, peak_time=0, peak_pileup=0, peak_valid=0, busy=0, ts=0, state IDLE.
- Latency: sample ending the pulse presented in cycle k -> peak_valid high in cycle k+1 only; record outputs change in the same cycle k+1 and hold.
- busy is registered: high from cycle after the triggering sample until cycle after HOLDOFF completes.
- Minimum spacing between two peak_valid strobes: 2 + HOLDOFF accepted samples.
- Throughput: one sample per clock, no backpressure.

## Test plan

- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately, ts restarts at 0 after release.
- Single pulse (in_valid=1 always): 0,50,150,300,300,200,80,0 -> peak_valid one cycle after the 80 sample, amplitude 300, peak_time = ts of first 300, pileup 0, exactly one strobe.
- Pile-up: 20 consecutive samples of 200 after 0 -> strobe the cycle after 16th sample, amplitude 200, pileup 1; no second strobe while input stays 200; drop to 0 and rise to 200 again -> new trigger.
- Holdoff: pulse 0,200,0 then 0,0,200 within 4 samples -> second pulse ignored; same pattern with crossing on 5th sample after end -> detected.
- Gaps: pulse of scenario 2 with in_valid=0 on alternate cycles -> amplitude 300, pileup 0, peak_time equals ts of cycle where first 300 was valid.
- Negative/edge: samples -500, 100, 100 -> no trigger (strictly greater); reset asserted during RISE -> no strobe, next pulse reported normally.

Source files
------------

// File: rtl/trap_peak_detector.sv
// Peak detector for the trapezoidal filter output: finds threshold-crossing pulses and
// emits one record per pulse (maximum, timestamp of maximum, pile-up flag).
module trap_peak_detector #(
  parameter int FILTER_W  = 22,
  parameter int TS_W      = 32,
  parameter int THRESHOLD = 100,
  parameter int HOLDOFF   = 4,
  parameter int MAX_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [FILTER_W-1:0] in_data,
  input  logic                       in_valid,
  output logic signed [FILTER_W-1:0] peak_amplitude,
  output logic [TS_W-1:0]            peak_time,
  output logic                       peak_pileup,
  output logic                       peak_valid,
  output logic                       busy
);

  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic signed [FILTER_W-1:0] THR       = FILTER_W'(THRESHOLD);
  localparam logic [WW-1:0]              MAXW      = WW'(MAX_WIDTH);
  localparam logic [HW-1:0]              HOLD_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {IDLE, RISE, HOLD} state_t;

  // With no holdoff a finished pulse returns straight to IDLE.
  localparam state_t POST = (HOLDOFF == 0) ? IDLE : HOLD;

  state_t                     state, state_nxt;
  logic [TS_W-1:0]            ts;
  logic                       prev_above;
  logic signed [FILTER_W-1:0] max_amp, max_nxt;
  logic [TS_W-1:0]            max_ts, maxts_nxt;
  logic [WW-1:0]              width, width_nxt;
  logic [HW-1:0]              hold_cnt, hold_nxt;
  logic                       above, emit, pileup;

  function automatic logic is_above(input logic signed [FILTER_W-1:0] s);
    return s > THR;
  endfunction

  assign above = is_above(in_data);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    max_nxt   = max_amp;
    maxts_nxt = max_ts;
    width_nxt = width;
    hold_nxt  = hold_cnt;
    emit      = 1'b0;
    pileup    = 1'b0;
    if (in_valid) begin
      unique case (state)
        IDLE: begin
          if (above && !prev_above) begin
            state_nxt = RISE;
            max_nxt   = in_data;
            maxts_nxt = ts;
            width_nxt = WW'(1);
          end
        end
        RISE: begin
          if (above) begin
            // Strict compare: the earliest sample of a flat top keeps the timestamp.
            if (in_data > max_amp) begin
              max_nxt   = in_data;
              maxts_nxt = ts;
            end
            width_nxt = width + 1'b1;
            if (width_nxt == MAXW) begin
              emit      = 1'b1;
              pileup    = 1'b1;
              state_nxt = POST;
              hold_nxt  = '0;
            end
          end else begin
            emit      = 1'b1;
            state_nxt = POST;
            hold_nxt  = '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
          else                       hold_nxt  = hold_cnt + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts             <= '0;
      prev_above     <= 1'b0;
      max_amp        <= '0;
      max_ts         <= '0;
      width          <= '0;
      hold_cnt       <= '0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      peak_pileup    <= 1'b0;
      peak_valid     <= 1'b0;
    end else begin
      ts         <= ts + 1'b1;
      max_amp    <= max_nxt;
      max_ts     <= maxts_nxt;
      width      <= width_nxt;
      hold_cnt   <= hold_nxt;
      peak_valid <= emit;
      if (in_valid) prev_above <= above;
      if (emit) begin
        peak_amplitude <= max_nxt;
        peak_time      <= maxts_nxt;
        peak_pileup    <= pileup;
      end
    end
  end

endmodule

// File: tb/tb_trap_peak_detector.sv
// Directed bench for trap_peak_detector: expected peak records are queued as the pulse
// is driven and matched against each peak_valid strobe.
module tb_trap_peak_detector;

  localparam int FW = 22;
  localparam int TW = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic signed [FW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic signed [FW-1:0] peak_amplitude;
  logic [TW-1:0]        peak_time;
  logic                 peak_pileup;
  logic                 peak_valid;
  logic                 busy;

  trap_peak_detector #(
    .FILTER_W(FW), .TS_W(TW), .THRESHOLD(100), .HOLDOFF(4), .MAX_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .peak_amplitude(peak_amplitude), .peak_time(peak_time),
    .peak_pileup(peak_pileup), .peak_valid(peak_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] amp;
    logic [TW-1:0] tstamp;
    logic          pile;
    logic [TW-1:0] due;
  } rec_t;

  rec_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [TW-1:0] tb_ts = '0;
  logic [TW-1:0] cur_ts;

  always @(posedge clk) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one input cycle; it is captured at the next rising edge with timestamp cur_ts.
  task automatic put(input logic v, input int d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = FW'(d);
    cur_ts   = tb_ts;
  endtask

  task automatic expect_peak(input int amp, input logic [TW-1:0] t, input logic pile);
    rec_t r;
    r.amp    = FW'(amp);
    r.tstamp = t;
    r.pile   = pile;
    r.due    = cur_ts + 1;
    sb.push_back(r);
  endtask

  task automatic settle(input string tag);
    repeat (3) put(1, 0);
    check(tag, sb.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_amp"},  peak_amplitude, 0);
    check({tag, "_time"}, peak_time, 0);
    check({tag, "_pile"}, peak_pileup, 0);
    check({tag, "_vld"},  peak_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  always @(negedge clk) begin
    if (peak_valid) begin
      check("strobe_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        rec_t r;
        r = sb.pop_front();
        check("peak_amplitude", peak_amplitude, r.amp);
        check("peak_time",      peak_time,      r.tstamp);
        check("peak_pileup",    peak_pileup,    r.pile);
        check("strobe_cycle",   tb_ts,          r.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] t1, t2;

    // reset state
    #1 reset = 1'b1;
    #2 check_zero_outputs("reset_init");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // single pulse
    put(1, 0); put(1, 50); put(1, 150);
    put(1, 300); t1 = cur_ts;
    check("busy_rise", busy, 1);
    put(1, 300); put(1, 200);
    put(1, 80); expect_peak(300, t1, 1'b0);
    repeat (4) put(1, 0);
    check("busy_holdoff", busy, 1);
    put(1, 0);
    check("busy_idle", busy, 0);
    settle("single_pending");

    // holdoff: crossing inside the window is ignored
    put(1, 200); t1 = cur_ts;
    put(1, 0); expect_peak(200, t1, 1'b0);
    put(1, 0); put(1, 0); put(1, 200); put(1, 0);
    repeat (4) put(1, 0);
    settle("holdoff_ignored");
    // crossing on the fifth sample after the end is detected
    put(1, 200); t1 = cur_ts;
    put(1, 0); expect_peak(200, t1, 1'b0);
    repeat (4) put(1, 0);
    put(1, 200); t2 = cur_ts;
    put(1, 0); expect_peak(200, t2, 1'b0);
    settle("holdoff_edge");

    // gaps: invalid cycles carry junk that must be ignored
    put(1, 0); put(0, 1000); put(1, 50); put(0, 1000); put(1, 150); put(0, 1000);
    put(1, 300); t1 = cur_ts;
    put(0, 1000); put(1, 300); put(0, 1000); put(1, 200); put(0, 1000);
    put(1, 80); expect_peak(300, t1, 1'b0);
    put(0, 1000); put(0, 1000);
    repeat (5) put(1, 0);
    settle("gaps_pending");

    // pile-up
    put(1, 0);
    for (int i = 1; i <= 26; i++) begin
      put(1, 200);
      if (i == 1) t1 = cur_ts;
      if (i == 16) expect_peak(200, t1, 1'b1);
    end
    check("pileup_busy_done", busy, 0);
    check("pileup_queue", sb.size(), 0);
    put(1, 0);
    put(1, 200); t2 = cur_ts;
    put(1, 0); expect_peak(200, t2, 1'b0);
    repeat (4) put(1, 0);
    settle("pileup_retrigger");

    // negative and exactly-at-threshold samples do not trigger
    put(1, -500); put(1, 100); put(1, 100);
    put(1, 0);
    check("no_trigger_busy", busy, 0);
    settle("no_trigger");

    // leave a pile-up record held, then reset mid-cycle during a pulse
    for (int i = 1; i <= 16; i++) begin
      put(1, 150);
      if (i == 1) t1 = cur_ts;
      if (i == 16) expect_peak(150, t1, 1'b1);
    end
    repeat (6) put(1, 0);
    check("pre_reset_pile", peak_pileup, 1);
    put(1, 200); put(1, 250);
    @(posedge clk);
    #3;
    reset = 1'b1;
    in_valid = 1'b0;
    #1 check_zero_outputs("reset_async");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    put(1, 0);
    put(1, 400); t1 = cur_ts;
    check("ts_restart", t1, 2);
    put(1, 0); expect_peak(400, t1, 1'b0);
    settle("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
